// File: rtl/spi_bus_bridge_if.sv
// SPI pin and bus-master signal bundle for the SPI-to-bus bridge.
interface spi_bus_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 18
);
    logic                  spi_cs_ni;
    logic                  spi_sck_i;
    logic                  spi_sd_i;
    logic                  spi_sd_o;
    logic                  spi_stall_o;
    logic [ADDR_WIDTH-1:0] wb_addr_o;
    logic [7:0]            wb_data_o;
    logic [7:0]            wb_data_i;
    logic                  wb_we_o;
    logic                  wb_cycle_o;
    logic                  wb_ack_i;
    logic                  error_o;

    // Bridge side: SPI slave towards the MCU, bus master towards the arbiter.
    modport slave (
        input  spi_cs_ni, spi_sck_i, spi_sd_i, wb_data_i, wb_ack_i,
        output spi_sd_o, spi_stall_o, wb_addr_o, wb_data_o, wb_we_o,
               wb_cycle_o, error_o
    );

    // Environment side: SPI host pins plus the bus target.
    modport master (
        output spi_cs_ni, spi_sck_i, spi_sd_i, wb_data_i, wb_ack_i,
        input  spi_sd_o, spi_stall_o, wb_addr_o, wb_data_o, wb_we_o,
               wb_cycle_o, error_o
    );
endinterface

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns command/address/data frames into acked bus
// cycles, with burst auto-increment, read prefetch and an ack timeout.
module spi_bus_bridge #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    spi_bus_bridge_if.slave bus
);

    localparam int unsigned ABYTES = (ADDR_WIDTH + 7) / 8;
    localparam int unsigned ABW    = (ABYTES > 1) ? $clog2(ABYTES) : 1;
    localparam int unsigned TW     = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_BUS   = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sd_sync;
    logic                   cs_prev, sck_prev;
    logic                   cs_s, sck_s, sd_s;

    logic [2:0]            bit_cnt_q;
    logic [6:0]            rx_q;
    logic [7:0]            tx_q, tx_d;
    logic [ABW-1:0]        abyte_q;
    logic [TW-1:0]         tmo_q;
    logic                  rd_q, inc_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic       cycle_q, cycle_d, stall_q, stall_d, we_q, we_d;
    logic       error_q, error_d, sd_q, sd_d;
    logic [7:0] wdata_q, wdata_d;

    logic       in_frame, bus_busy, bit_live;
    logic       sck_rise, sck_fall, cs_fall;
    logic       byte_done, last_abyte, tmo_hit, bus_done, cycle_start;
    logic [7:0] rx_byte;

    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    assign in_frame   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign bus_busy   = (state_q == S_BUS) || (state_q == S_DRAIN);
    assign bit_live   = in_frame & ~cs_s;
    assign rx_byte    = {rx_q, sd_s};
    assign byte_done  = bit_live & sck_rise & (bit_cnt_q == 3'd7);
    assign last_abyte = (abyte_q == ABW'(ABYTES - 1));
    assign tmo_hit    = bus_busy & ~bus.wb_ack_i & (tmo_q == TW'(ACK_TIMEOUT - 1));
    assign bus_done   = bus_busy & (bus.wb_ack_i | tmo_hit);
    // Reads issue after the last address byte and after every data byte.
    assign cycle_start = byte_done &
                         (((state_q == S_ADDR) & last_abyte & rd_q) | (state_q == S_DATA));

    assign bus.spi_sd_o    = sd_q;
    assign bus.spi_stall_o = stall_q;
    assign bus.wb_addr_o   = addr_q;
    assign bus.wb_data_o   = wdata_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_cycle_o  = cycle_q;
    assign bus.error_o     = error_q;

    // Input synchronisers; CS resets to its inactive level to avoid a false frame start.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            sd_sync  <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_ni};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], bus.spi_sd_i};
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
        end
    end

    // State register.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; a CS release mid-frame abandons it, during a cycle it drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cs_fall) state_d = S_CMD;
            S_CMD: begin
                if (cs_s)           state_d = S_IDLE;
                else if (byte_done) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (cs_s)                          state_d = S_IDLE;
                else if (byte_done && last_abyte)  state_d = rd_q ? S_BUS : S_DATA;
            end
            S_DATA: begin
                if (cs_s)           state_d = S_IDLE;
                else if (byte_done) state_d = S_BUS;
            end
            S_BUS: begin
                if (bus_done)  state_d = cs_s ? S_IDLE : S_DATA;
                else if (cs_s) state_d = S_DRAIN;
            end
            S_DRAIN: if (bus_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the MISO shifter.
    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        error_d = error_q;
        tx_d    = tx_q;
        if (state_q == S_IDLE) tx_d = '0;
        if (cycle_start) begin
            cycle_d = 1'b1;
            stall_d = 1'b1;
            we_d    = ~rd_q;
            if (!rd_q) wdata_d = rx_byte;
        end
        if (bus_done) begin
            cycle_d = 1'b0;
            stall_d = 1'b0;
            if ((state_q == S_BUS) && rd_q) tx_d = bus.wb_ack_i ? bus.wb_data_i : 8'hFF;
        end
        // The falling edge after a byte's 8th bit must not consume freshly loaded data.
        if (bit_live && sck_fall && (bit_cnt_q != 3'd0)) tx_d = {tx_q[6:0], 1'b0};
        if (tmo_hit)                              error_d = 1'b1;
        else if ((state_q == S_IDLE) && cs_fall)  error_d = 1'b0;
        sd_d = ~cs_s & tx_d[7];
    end

    // Datapath and output registers.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            abyte_q   <= '0;
            tmo_q     <= '0;
            rd_q      <= 1'b0;
            inc_q     <= 1'b0;
            addr_q    <= '0;
            cycle_q   <= 1'b0;
            stall_q   <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            error_q   <= 1'b0;
            sd_q      <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
            tx_q    <= tx_d;
            sd_q    <= sd_d;

            if (!bit_live)     bit_cnt_q <= '0;
            else if (sck_rise) bit_cnt_q <= bit_cnt_q + 3'd1;

            if (bit_live && sck_rise) rx_q <= rx_byte[6:0];

            if ((state_q == S_CMD) && byte_done) begin
                rd_q    <= rx_byte[7];
                inc_q   <= rx_byte[6];
                abyte_q <= '0;
            end

            if ((state_q == S_ADDR) && byte_done) begin
                addr_q  <= (addr_q << 8) | ADDR_WIDTH'(rx_byte);
                abyte_q <= abyte_q + ABW'(1);
            end else if (bus_done && inc_q) begin
                addr_q  <= addr_q + ADDR_WIDTH'(1);
            end

            if (bus_busy && !bus_done) tmo_q <= tmo_q + TW'(1);
            else                       tmo_q <= '0;
        end
    end

endmodule
